// File: rtl/sya_pkg.sv
// Shared definitions for the systolic-array deskew/repack stage.
// Holds the default activation width and the per-bank FSM state encoding.
// Build option: `SYA_DESKEW_FLUSH_EN enables the tail-flush state in the banks.
package sya_pkg;

  localparam int ACT_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    DSK_IDLE  = 2'd0,
    DSK_RUN   = 2'd1,
    DSK_FLUSH = 2'd2
  } dsk_state_e;

endpackage

// File: rtl/sya_deskew_bank.sv
// One deskew bank: per-lane write pointers into a shared slot ring, one read pointer,
// and a registered output stage loaded when every active lane has an element at the head.
// Build option: `SYA_DESKEW_FLUSH_EN adds the flush/flush-done handshake and FLUSH state.
module sya_deskew_bank
  import sya_pkg::*;
#(
  parameter  int ACT_WIDTH  = ACT_WIDTH_DEF,
  parameter  int NUM_ROW    = 16,
  parameter  int SLOT_DEPTH = 8,
  localparam int SLOT_AW    = $clog2(SLOT_DEPTH),
  localparam int ROW_AW     = $clog2(NUM_ROW + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [ROW_AW-1:0]            i_row_num,
  input  logic [NUM_ROW*ACT_WIDTH-1:0] i_din_data,
  input  logic [NUM_ROW-1:0]           i_din_vld,
  output logic [NUM_ROW-1:0]           o_din_rdy,
  output logic [NUM_ROW*ACT_WIDTH-1:0] o_out_data,
  output logic                         o_out_vld,
  input  logic                         i_out_rdy,
`ifdef SYA_DESKEW_FLUSH_EN
  input  logic                         i_flush,
  output logic                         o_flush_done,
`endif
  output logic                         o_busy
);

  // Pointers carry one extra wrap bit so full (occ==SLOT_DEPTH) and empty differ.
  typedef logic [SLOT_AW:0] ptr_t;

  ptr_t                         r_wp [NUM_ROW];
  ptr_t                         r_rp;
  logic [ACT_WIDTH-1:0]         r_mem [SLOT_DEPTH][NUM_ROW];
  logic [NUM_ROW*ACT_WIDTH-1:0] r_out_data;
  logic                         r_out_vld;
  dsk_state_e                   r_state;

  ptr_t                         w_occ [NUM_ROW];
  logic [ACT_WIDTH-1:0]         w_wdat [NUM_ROW];
  logic [NUM_ROW-1:0]           w_act;
  logic [NUM_ROW-1:0]           w_nz;
  logic [NUM_ROW-1:0]           w_wr;
  logic [NUM_ROW-1:0]           w_pad;
  logic                         w_complete;
  logic                         w_partial;
  logic                         w_load;
  logic                         w_in_flush;
  logic                         w_flush_req;
  ptr_t                         w_rp_nxt;
  logic [NUM_ROW*ACT_WIDTH-1:0] w_head;

`ifdef SYA_DESKEW_FLUSH_EN
  logic r_flush_done;
  logic w_wp_eq;

  assign w_in_flush   = (r_state == DSK_FLUSH);
  assign w_flush_req  = i_flush;
  assign o_flush_done = r_flush_done;

  // No partial slot remains once every active lane points at the same slot.
  always_comb begin
    w_wp_eq = 1'b1;
    for (int r = 0; r < NUM_ROW; r++) begin
      if (w_act[r] && (r_wp[r] != r_wp[0])) w_wp_eq = 1'b0;
    end
  end
`else
  assign w_in_flush  = 1'b0;
  assign w_flush_req = 1'b0;
`endif

  // Lane occupancy, input handshake, head completeness and flush padding.
  always_comb begin
    w_act      = '0;
    w_nz       = '0;
    w_wr       = '0;
    w_pad      = '0;
    o_din_rdy  = '0;
    w_complete = 1'b1;
    for (int r = 0; r < NUM_ROW; r++) begin
      w_act[r]     = (ROW_AW'(r) < i_row_num);
      w_occ[r]     = r_wp[r] - r_rp;
      w_nz[r]      = (w_occ[r] != '0);
      o_din_rdy[r] = w_act[r] && !w_occ[r][SLOT_AW] && !w_in_flush;
      w_wr[r]      = o_din_rdy[r] && i_din_vld[r];
      if (w_act[r] && !w_nz[r]) w_complete = 1'b0;
    end
    w_partial = !w_complete && (|(w_nz & w_act));
    for (int r = 0; r < NUM_ROW; r++) begin
      w_pad[r]  = w_in_flush && w_partial && w_act[r] && !w_nz[r];
      w_wdat[r] = w_pad[r] ? '0 : i_din_data[r*ACT_WIDTH +: ACT_WIDTH];
    end
  end

  // Head slot read and output-register load decision; inactive rows read as zero.
  always_comb begin
    w_head = '0;
    for (int r = 0; r < NUM_ROW; r++) begin
      if (w_act[r]) w_head[r*ACT_WIDTH +: ACT_WIDTH] = r_mem[r_rp[SLOT_AW-1:0]][r];
    end
    w_load   = w_complete && (!r_out_vld || i_out_rdy);
    w_rp_nxt = r_rp + ptr_t'(w_load);
  end

  assign o_busy     = r_out_vld || (|w_nz);
  assign o_out_vld  = r_out_vld;
  assign o_out_data = r_out_data;

  // Slot storage: lane writes and flush padding; never reset.
  always_ff @(posedge clk) begin
    for (int r = 0; r < NUM_ROW; r++) begin
      if (w_wr[r] || w_pad[r]) r_mem[r_wp[r][SLOT_AW-1:0]][r] <= w_wdat[r];
    end
  end

  // Pointer update; inactive lanes track the read pointer so they stay empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rp <= '0;
      for (int r = 0; r < NUM_ROW; r++) r_wp[r] <= '0;
    end else begin
      r_rp <= w_rp_nxt;
      for (int r = 0; r < NUM_ROW; r++) begin
        if (!w_act[r])                r_wp[r] <= w_rp_nxt;
        else if (w_wr[r] || w_pad[r]) r_wp[r] <= r_wp[r] + ptr_t'(1);
      end
    end
  end

  // Output register: load a complete head, otherwise drop valid after the handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_vld  <= 1'b0;
      r_out_data <= '0;
    end else if (w_load) begin
      r_out_vld  <= 1'b1;
      r_out_data <= w_head;
    end else if (i_out_rdy) begin
      r_out_vld  <= 1'b0;
    end
  end

  // Bank state machine: idle/run tracking plus the optional flush sequence.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= DSK_IDLE;
`ifdef SYA_DESKEW_FLUSH_EN
      r_flush_done <= 1'b0;
`endif
    end else begin
`ifdef SYA_DESKEW_FLUSH_EN
      r_flush_done <= 1'b0;
`endif
      case (r_state)
        DSK_IDLE: begin
          if (w_flush_req)  r_state <= DSK_FLUSH;
          else if (|w_wr)   r_state <= DSK_RUN;
        end
        DSK_RUN: begin
          if (w_flush_req)                r_state <= DSK_FLUSH;
          else if (!o_busy && !(|w_wr))   r_state <= DSK_IDLE;
        end
`ifdef SYA_DESKEW_FLUSH_EN
        DSK_FLUSH: begin
          if (w_wp_eq) begin
            r_flush_done <= 1'b1;
            r_state      <= o_busy ? DSK_RUN : DSK_IDLE;
          end
        end
`endif
        default: r_state <= DSK_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/sya_deskew_pack.sv
// Deskew/repack stage between systolic-array row outputs and the output SRAM writer.
// Output latency: last missing element accepted at edge E -> out_data_vld after E+1; per-lane back-pressure.
// Build option: `SYA_DESKEW_FLUSH_EN adds flush/flush_done for padding partial tail slots.
module sya_deskew_pack
  import sya_pkg::*;
#(
  parameter  int ACT_WIDTH  = ACT_WIDTH_DEF,
  parameter  int NUM_ROW    = 16,
  parameter  int NUM_BANK   = 4,
  parameter  int SLOT_DEPTH = 8,
  localparam int ROW_AW     = $clog2(NUM_ROW + 1)
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [ROW_AW-1:0]                     cfg_row_num,
  output logic [NUM_BANK-1:0]                   busy,
  input  logic [NUM_BANK*NUM_ROW*ACT_WIDTH-1:0] din_data,
  input  logic [NUM_BANK*NUM_ROW-1:0]           din_data_vld,
  output logic [NUM_BANK*NUM_ROW-1:0]           din_data_rdy,
  output logic [NUM_BANK*NUM_ROW*ACT_WIDTH-1:0] out_data,
  output logic [NUM_BANK-1:0]                   out_data_vld,
  input  logic [NUM_BANK-1:0]                   out_data_rdy
`ifdef SYA_DESKEW_FLUSH_EN
  ,
  input  logic                                  flush,
  output logic [NUM_BANK-1:0]                   flush_done
`endif
);

  logic [ROW_AW-1:0] r_row_num;
  logic [ROW_AW-1:0] w_cfg_row_num;
  logic              w_cfg_open;

  // Clamp the requested row count into 1..NUM_ROW so a bank always has an active lane.
  always_comb begin
    w_cfg_row_num = cfg_row_num;
    if (cfg_row_num == '0)                       w_cfg_row_num = ROW_AW'(1);
    else if (cfg_row_num > ROW_AW'(NUM_ROW))     w_cfg_row_num = ROW_AW'(NUM_ROW);
  end

  // Row count may only change while every bank is empty and no lane is writing.
  assign w_cfg_open = (busy == '0) && ((din_data_vld & din_data_rdy) == '0);

  // Shared row-count register.
  always_ff @(posedge clk) begin
    if (rst)             r_row_num <= ROW_AW'(NUM_ROW);
    else if (w_cfg_open) r_row_num <= w_cfg_row_num;
  end

  for (genvar b = 0; b < NUM_BANK; b++) begin : g_bank
    sya_deskew_bank #(
      .ACT_WIDTH  (ACT_WIDTH),
      .NUM_ROW    (NUM_ROW),
      .SLOT_DEPTH (SLOT_DEPTH)
    ) u_bank (
      .clk          (clk),
      .rst          (rst),
      .i_row_num    (r_row_num),
      .i_din_data   (din_data[b*NUM_ROW*ACT_WIDTH +: NUM_ROW*ACT_WIDTH]),
      .i_din_vld    (din_data_vld[b*NUM_ROW +: NUM_ROW]),
      .o_din_rdy    (din_data_rdy[b*NUM_ROW +: NUM_ROW]),
      .o_out_data   (out_data[b*NUM_ROW*ACT_WIDTH +: NUM_ROW*ACT_WIDTH]),
      .o_out_vld    (out_data_vld[b]),
      .i_out_rdy    (out_data_rdy[b]),
`ifdef SYA_DESKEW_FLUSH_EN
      .i_flush      (flush),
      .o_flush_done (flush_done[b]),
`endif
      .o_busy       (busy[b])
    );
  end

endmodule

// File: tb/tb_sya_deskew_pack.sv
// Scoreboard bench for sya_deskew_pack: 2 banks x 4 rows x 8-bit, 8 slots.
// Lane drivers feed per-lane queues with optional skew; a monitor checks every output handshake.
`timescale 1ns/1ps
module tb_sya_deskew_pack;
  localparam int AW  = 8;
  localparam int NR  = 4;
  localparam int NB  = 2;
  localparam int SD  = 8;
  localparam int RAW = $clog2(NR + 1);

  logic                 clk = 1'b0;
  logic                 rst;
  logic [RAW-1:0]       cfg_row_num;
  logic [NB-1:0]        busy;
  logic [NB*NR*AW-1:0]  din_data;
  logic [NB*NR-1:0]     din_data_vld;
  logic [NB*NR-1:0]     din_data_rdy;
  logic [NB*NR*AW-1:0]  out_data;
  logic [NB-1:0]        out_data_vld;
  logic [NB-1:0]        out_data_rdy;
`ifdef SYA_DESKEW_FLUSH_EN
  logic                 flush;
  logic [NB-1:0]        flush_done;
`endif

  always #5 clk = ~clk;

  sya_deskew_pack #(.ACT_WIDTH(AW), .NUM_ROW(NR), .NUM_BANK(NB), .SLOT_DEPTH(SD)) dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_row_num  (cfg_row_num),
    .busy         (busy),
    .din_data     (din_data),
    .din_data_vld (din_data_vld),
    .din_data_rdy (din_data_rdy),
    .out_data     (out_data),
    .out_data_vld (out_data_vld),
    .out_data_rdy (out_data_rdy)
`ifdef SYA_DESKEW_FLUSH_EN
    ,
    .flush        (flush),
    .flush_done   (flush_done)
`endif
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [AW-1:0]    lane_q [NB][NR][$];
  int               lane_dly [NB][NR];
  bit               lane_force [NB][NR];
  bit               hs [NB][NR];
  logic [NR*AW-1:0] exp_q [NB][$];

  bit meas      = 1'b0;
  bit chk_drop  = 1'b0;
  int hs_cyc    = -1;
  int vfirst    = -1;
  int vlast     = -1;
  int drop_cnt  = 0;

  function automatic logic [AW-1:0] val(input int b, input int base, input int k);
    return AW'(b * 128 + base + k);
  endfunction

  function automatic logic [NR*AW-1:0] pk(input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                                          input logic [AW-1:0] a2, input logic [AW-1:0] a3);
    return {a3, a2, a1, a0};
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    bit done = 1'b0;
    while (!done && n < budget) begin
      done = 1'b1;
      for (int b = 0; b < NB; b++) begin
        if (exp_q[b].size() != 0 || busy[b]) done = 1'b0;
        for (int r = 0; r < NR; r++) if (lane_q[b][r].size() != 0) done = 1'b0;
      end
      if (!done) begin
        tick(1);
        n++;
      end
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s drain timeout: exp0 left=%0d exp1 left=%0d busy=%b", name,
               exp_q[0].size(), exp_q[1].size(), busy);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Lane drivers: handshakes sampled on the falling edge, queues advanced after the rising edge.
  initial begin
    din_data_vld = '0;
    din_data     = '0;
    forever begin
      @(negedge clk);
      for (int b = 0; b < NB; b++) begin
        for (int r = 0; r < NR; r++) begin
          hs[b][r] = din_data_vld[b*NR+r] && din_data_rdy[b*NR+r];
          if (chk_drop && din_data_vld[b*NR+r] && !din_data_rdy[b*NR+r]) drop_cnt++;
        end
      end
      if (meas && hs[0][0] && hs_cyc < 0) hs_cyc = cyc;
      @(posedge clk);
      #1;
      for (int b = 0; b < NB; b++) begin
        for (int r = 0; r < NR; r++) begin
          bit offer;
          if (hs[b][r] && lane_q[b][r].size() > 0) void'(lane_q[b][r].pop_front());
          if (lane_q[b][r].size() > 0 && lane_dly[b][r] > 0) begin
            lane_dly[b][r]--;
            offer = 1'b0;
          end else begin
            offer = (lane_q[b][r].size() > 0);
          end
          din_data_vld[b*NR+r]        = offer || lane_force[b][r];
          din_data[(b*NR+r)*AW +: AW] = (lane_q[b][r].size() > 0) ? lane_q[b][r][0] : 8'hEE;
        end
      end
    end
  end

  // Output monitor: every output handshake pops and compares the oldest expected slot.
  always @(negedge clk) begin
    for (int b = 0; b < NB; b++) begin
      if (!rst && out_data_vld[b] && out_data_rdy[b]) begin
        logic [NR*AW-1:0] got;
        got = out_data[b*NR*AW +: NR*AW];
        checks++;
        if (exp_q[b].size() == 0) begin
          errors++;
          $display("FAIL out_unexpected bank=%0d got=%h exp=none", b, got);
        end else begin
          logic [NR*AW-1:0] e;
          e = exp_q[b].pop_front();
          if (got !== e) begin
            errors++;
            $display("FAIL out_slot bank=%0d got=%h exp=%h", b, got, e);
          end
        end
        if (meas && b == 0) begin
          if (vfirst < 0) vfirst = cyc;
          vlast = cyc;
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst          = 1'b1;
    cfg_row_num  = RAW'(4);
    out_data_rdy = '1;
`ifdef SYA_DESKEW_FLUSH_EN
    flush        = 1'b0;
`endif
    for (int b = 0; b < NB; b++)
      for (int r = 0; r < NR; r++) begin
        lane_dly[b][r]   = 0;
        lane_force[b][r] = 1'b0;
      end
    tick(3);
    chk("rst_out_vld",  64'(out_data_vld), 64'd0);
    chk("rst_out_data", 64'(out_data),     64'd0);
    chk("rst_busy",     64'(busy),         64'd0);
    chk("rst_din_rdy",  64'(din_data_rdy), 64'hFF);
    rst = 1'b0;
    tick(2);

    // T1 aligned: all lanes send 1..8 together.
    meas = 1'b1;
    for (int b = 0; b < NB; b++)
      for (int k = 1; k <= 8; k++) begin
        for (int r = 0; r < NR; r++) lane_q[b][r].push_back(val(b, 0, k));
        exp_q[b].push_back(pk(val(b, 0, k), val(b, 0, k), val(b, 0, k), val(b, 0, k)));
      end
    wait_drain("t1", 80);
    meas = 1'b0;
    chk("t1_first_latency", 64'(vfirst - hs_cyc), 64'd2);
    chk("t1_back_to_back",  64'(vlast - vfirst),  64'd7);

    // T2 skew: lane r starts r cycles late, values 0x10*r+k.
    drop_cnt = 0;
    chk_drop = 1'b1;
    for (int b = 0; b < NB; b++) begin
      for (int r = 0; r < NR; r++) lane_dly[b][r] = r;
      for (int k = 1; k <= 8; k++) begin
        for (int r = 0; r < NR; r++) lane_q[b][r].push_back(val(b, 16*r, k));
        exp_q[b].push_back(pk(val(b, 0, k), val(b, 16, k), val(b, 32, k), val(b, 48, k)));
      end
    end
    wait_drain("t2", 80);
    chk_drop = 1'b0;
    chk("t2_no_rdy_drop", 64'(drop_cnt), 64'd0);

    // T3 back-pressure: lane 0 alone sends 9 beats with the output stalled.
    out_data_rdy = '0;
    for (int b = 0; b < NB; b++)
      for (int k = 1; k <= 9; k++) lane_q[b][0].push_back(val(b, 0, k));
    tick(14);
    chk("t3_lane0_full_rdy",  64'(din_data_rdy[0]),   64'd0);
    chk("t3_lane1_3_rdy",     64'(din_data_rdy[3:1]), 64'h7);
    chk("t3_bank1_lane0_rdy", 64'(din_data_rdy[4]),   64'd0);
    chk("t3_lane0_left",      64'(lane_q[0][0].size()), 64'd1);
    for (int b = 0; b < NB; b++)
      for (int k = 1; k <= 9; k++) begin
        for (int r = 1; r < NR; r++) lane_q[b][r].push_back(val(b, 16*r, k));
        exp_q[b].push_back(pk(val(b, 0, k), val(b, 16, k), val(b, 32, k), val(b, 48, k)));
      end
    out_data_rdy = '1;
    wait_drain("t3", 100);

    // T4 three active rows of four; lane 3 holds valid high throughout.
    cfg_row_num = RAW'(3);
    tick(3);
    out_data_rdy = '0;
    for (int b = 0; b < NB; b++) begin
      lane_force[b][3] = 1'b1;
      for (int k = 1; k <= 3; k++) begin
        for (int r = 0; r < 3; r++) lane_q[b][r].push_back(val(b, 16*r, k));
        exp_q[b].push_back(pk(val(b, 0, k), val(b, 16, k), val(b, 32, k), 8'h00));
      end
    end
    tick(8);
    chk("t4_lane3_rdy", 64'(din_data_rdy[3]), 64'd0);
    chk("t4_busy",      64'(busy),            64'h3);
    // T4b: a config write while busy must not take effect.
    cfg_row_num = RAW'(4);
    tick(3);
    chk("t4b_cfg_held", 64'(din_data_rdy[3]), 64'd0);
    for (int b = 0; b < NB; b++) lane_force[b][3] = 1'b0;
    out_data_rdy = '1;
    wait_drain("t4", 60);
    tick(2);
    chk("t4b_cfg_applied", 64'(din_data_rdy[3]), 64'd1);

    // T5 reset with three slots queued and the output stalled.
    out_data_rdy = '0;
    for (int b = 0; b < NB; b++)
      for (int k = 1; k <= 3; k++)
        for (int r = 0; r < NR; r++) lane_q[b][r].push_back(val(b, 64, k));
    tick(8);
    chk("t5_pre_out_vld", 64'(out_data_vld), 64'h3);
    rst = 1'b1;
    tick(1);
    chk("t5_out_vld", 64'(out_data_vld), 64'd0);
    chk("t5_busy",    64'(busy),         64'd0);
    chk("t5_din_rdy", 64'(din_data_rdy), 64'hFF);
    rst = 1'b0;
    tick(1);
    for (int b = 0; b < NB; b++) begin
      for (int r = 0; r < NR; r++) lane_q[b][r].push_back(val(b, 80 + r, 0));
      exp_q[b].push_back(pk(val(b, 80, 0), val(b, 81, 0), val(b, 82, 0), val(b, 83, 0)));
    end
    out_data_rdy = '1;
    wait_drain("t5", 40);

`ifdef SYA_DESKEW_FLUSH_EN
    // T6 flush: lanes 0,1 one beat each, lanes 2,3 silent.
    begin
      int fd_cnt = 0;
      for (int b = 0; b < NB; b++) begin
        lane_q[b][0].push_back(val(b, 97, 0));
        lane_q[b][1].push_back(val(b, 114, 0));
        exp_q[b].push_back(pk(val(b, 97, 0), val(b, 114, 0), 8'h00, 8'h00));
      end
      tick(4);
      chk("t6_partial_waits", 64'(out_data_vld), 64'd0);
      flush = 1'b1;
      tick(1);
      flush = 1'b0;
      for (int i = 0; i < 20; i++) begin
        if (flush_done[0]) fd_cnt++;
        tick(1);
      end
      chk("t6_flush_done_pulses", 64'(fd_cnt), 64'd1);
      wait_drain("t6", 40);
      chk("t6_busy_after", 64'(busy), 64'd0);
    end
`endif

    tick(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
